// File: rtl/setn_release_seq.sv
// setn_release_seq: after reset or a synchronized preset request, holds every
// SETN group low for HOLD_CYC cycles, then releases the groups one at a time
// in ascending order, GAP_CYC cycles apart. A new request restarts the
// sequence; DONE pulses once when the final group is released.
module setn_release_seq #(
  parameter int NGRP     = 4,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int SYNC_STG = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ_N,
  output logic [NGRP-1:0] SETN,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [2:0] LAST_GRP  = 3'(NGRP - 1);

  logic [SYNC_STG-1:0] sync_q;
  logic                req_s;

  state_e              state_q, state_d;
  logic [7:0]          hold_q, hold_d;
  logic [7:0]          gap_q, gap_d;
  logic [2:0]          grp_q, grp_d;
  logic [NGRP-1:0]     setn_q, setn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Synchronize the asynchronous request; reset loads the deasserted level.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, as a shift register must.
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STG-2:0], REQ_N};
  end

  assign req_s = ~sync_q[SYNC_STG-1];

  // State, counters and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      grp_q   <= '0;
      setn_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      grp_q   <= grp_d;
      setn_q  <= setn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: hold all groups low, then release them one by one.
  always_comb begin
    // NOTE: every target gets a default before the case so no path through
    // the logic leaves a signal unassigned and a latch is never inferred.
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    grp_d   = grp_q;
    setn_d  = setn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_HOLD;
          setn_d  = '0;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end

      ST_HOLD: begin
        if (req_s) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          setn_d[0] = 1'b1;
          gap_d     = '0;
          grp_d     = 3'd1;
          if (NGRP == 1) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      ST_RELEASE: begin
        if (req_s) begin
          state_d = ST_HOLD;
          setn_d  = '0;
          busy_d  = 1'b1;
          hold_d  = '0;
          gap_d   = '0;
          grp_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          for (int k = 0; k < NGRP; k++) begin
            if (grp_q == 3'(k)) setn_d[k] = 1'b1;
          end
          gap_d = '0;
          grp_d = grp_q + 3'd1;
          if (grp_q == LAST_GRP) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_HOLD;
        setn_d  = '0;
        busy_d  = 1'b1;
        hold_d  = '0;
        gap_d   = '0;
        grp_d   = '0;
      end
    endcase
  end

  assign SETN = setn_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_setn_release_seq.sv
// Bench for setn_release_seq: a default instance and an NGRP=1 instance share
// the same stimulus. The reference model tracks, per instance, the number of
// cycles since the last kick (reset or synchronized request) and derives the
// expected SETN/BUSY/DONE from the release schedule HOLD + k*GAP.
module tb_setn_release_seq;

  localparam int N0 = 4, H0 = 4, G0 = 2, S0 = 2;
  localparam int N1 = 1, H1 = 3, G1 = 5, S1 = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_N;
  logic [N0-1:0] setn0;
  logic          busy0, done0;
  logic [N1-1:0] setn1;
  logic          busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt0 = 0;

  // Reference model state.
  logic hist[$];          // REQ_N samples, newest first
  int   age[2];
  bit   act[2];
  bit   dn[2];

  setn_release_seq #(.NGRP(N0), .HOLD_CYC(H0), .GAP_CYC(G0), .SYNC_STG(S0)) u_dut0 (
    .CLK(CLK), .RST(RST), .REQ_N(REQ_N), .SETN(setn0), .BUSY(busy0), .DONE(done0)
  );

  setn_release_seq #(.NGRP(N1), .HOLD_CYC(H1), .GAP_CYC(G1), .SYNC_STG(S1)) u_dut1 (
    .CLK(CLK), .RST(RST), .REQ_N(REQ_N), .SETN(setn1), .BUSY(busy1), .DONE(done1)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_setn(input int id, input int ng, input int hc, input int gc);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < ng; k++) v[k] = act[id] ? (age[id] >= hc + k * gc) : 1'b1;
    return v;
  endfunction

  function automatic void upd(input int id, input logic r, input int last);
    if (r) begin
      age[id] = 0; act[id] = 1'b1; dn[id] = 1'b0;
    end else if (act[id]) begin
      age[id]++;
      if (age[id] == last) begin
        act[id] = 1'b0; dn[id] = 1'b1;
      end else begin
        dn[id] = 1'b0;
      end
    end else begin
      dn[id] = 1'b0;
    end
  endfunction

  // Advance the model by one rising edge using the inputs present at the edge.
  task automatic model_edge();
    logic r0, r1;
    if (RST) begin
      hist.delete();
      repeat (4) hist.push_back(1'b1);
      for (int i = 0; i < 2; i++) begin
        age[i] = 0; act[i] = 1'b1; dn[i] = 1'b0;
      end
    end else begin
      r0 = ~hist[S0-1];
      r1 = ~hist[S1-1];
      hist.push_front(REQ_N);
      void'(hist.pop_back());
      upd(0, r0, H0 + (N0 - 1) * G0);
      upd(1, r1, H1 + (N1 - 1) * G1);
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_setn0"}, 32'(setn0), 32'(exp_setn(0, N0, H0, G0)));
    chk({pfx, "_busy0"}, 32'(busy0), 32'(act[0]));
    chk({pfx, "_done0"}, 32'(done0), 32'(dn[0]));
    chk({pfx, "_setn1"}, 32'(setn1), 32'(exp_setn(1, N1, H1, G1)));
    chk({pfx, "_busy1"}, 32'(busy1), 32'(act[1]));
    chk({pfx, "_done1"}, 32'(done1), 32'(dn[1]));
  endtask

  // One clock cycle, entered at posedge+1: REQ_N glitches, settles at a
  // random point, outputs must not move before the edge, then the edge.
  task automatic cycle(input logic rst, input logic reqn);
    int d;
    d = $urandom_range(1, 6);
    REQ_N = 1'($urandom_range(0, 1));
    #d;
    RST   = rst;
    REQ_N = reqn;
    #(7 - d);
    check_outputs("stable");
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs("edge");
    if (done0 === 1'b1) done_cnt0++;
  endtask

  task automatic wait_setn(input logic [N0-1:0] target, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (setn0 === target) seen = 1'b1;
      else cycle(1'b0, 1'b1);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    repeat (4) hist.push_back(1'b1);
    RST   = 1'b1;
    REQ_N = 1'b1;

    // Reset sequence: three reset edges, then a full release.
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs("rst0");
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    done_cnt0 = 0;
    repeat (16) cycle(1'b0, 1'b1);
    chk("rst_done_count", 32'(done_cnt0), 32'd1);
    chk("rst_final_setn", 32'(setn0), 32'hF);
    chk("rst_final_busy", 32'(busy0), 32'd0);

    // Idle request: one-cycle low pulse.
    done_cnt0 = 0;
    cycle(1'b0, 1'b0);
    repeat (18) cycle(1'b0, 1'b1);
    chk("idle_done_count", 32'(done_cnt0), 32'd1);

    // Extended request: ten cycles low.
    done_cnt0 = 0;
    repeat (10) cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1);
    chk("ext_done_count", 32'(done_cnt0), 32'd1);

    // Restart while SETN=0011.
    done_cnt0 = 0;
    cycle(1'b0, 1'b0);
    wait_setn(4'b0011, 30, "restart_wait");
    cycle(1'b0, 1'b0);
    repeat (22) cycle(1'b0, 1'b1);
    chk("restart_done_count", 32'(done_cnt0), 32'd1);

    // Reset priority: RST lands at SETN=0111 together with req_s=1.
    cycle(1'b0, 1'b0);
    wait_setn(4'b0011, 30, "rprio_wait");
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("rprio_pre_setn", 32'(setn0), 32'h7);
    cycle(1'b1, 1'b0);
    chk("rprio_setn", 32'(setn0), 32'h0);
    chk("rprio_busy", 32'(busy0), 32'd1);
    chk("rprio_done", 32'(done0), 32'd0);
    done_cnt0 = 0;
    repeat (25) cycle(1'b0, 1'b1);
    chk("rprio_done_count", 32'(done_cnt0), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
